// File: rtl/inst_loader.sv
// Boot-time program loader: receives a framed byte stream (length, little-endian
// words, XOR checksum), writes the words to instruction memory, and releases the core.
module inst_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN0  = 3'd1,
        S_LEN1  = 3'd2,
        S_DATA  = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam logic [32:0] DEPTH_C = 33'(1) << ADDR_W;

    state_t              state_q;
    logic [7:0]          len_lo_q;
    logic [15:0]         n_q;
    logic [15:0]         word_idx_q;
    logic [1:0]          byte_cnt_q;
    logic [7:0]          xor_q;
    logic [23:0]         word_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_waddr_q;
    logic [31:0]         mem_wdata_q;
    logic                core_rst_n_q;
    logic                done_q;
    logic                err_q;

    logic                ready_s;
    logic                xfer_s;
    logic [15:0]         len_d;

    // Ready is a pure decode of the current state so a stalled source never loses a byte.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_DATA, S_CSUM: ready_s = 1'b1;
            default:                        ready_s = 1'b0;
        endcase
    end

    assign xfer_s = s_valid & ready_s;
    assign len_d  = {s_data, len_lo_q};

    // Frame FSM with datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'd0;
            n_q          <= 16'd0;
            word_idx_q   <= 16'd0;
            byte_cnt_q   <= 2'd0;
            xor_q        <= 8'd0;
            word_q       <= 24'd0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= 32'd0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q      <= S_LEN0;
                        word_idx_q   <= 16'd0;
                        byte_cnt_q   <= 2'd0;
                        xor_q        <= 8'd0;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                    end else begin
                        state_q <= state_q;
                    end
                end
                S_LEN0: begin
                    if (xfer_s) begin
                        len_lo_q <= s_data;
                        state_q  <= S_LEN1;
                    end else begin
                        state_q <= S_LEN0;
                    end
                end
                S_LEN1: begin
                    if (xfer_s) begin
                        n_q <= len_d;
                        if ({17'd0, len_d} > DEPTH_C) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        state_q <= S_LEN1;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        xor_q      <= xor_q ^ s_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= s_data;
                            2'd1: word_q[15:8]  <= s_data;
                            2'd2: word_q[23:16] <= s_data;
                            default: begin
                                // Fourth byte completes the word; write it next cycle.
                                mem_we_q    <= 1'b1;
                                mem_waddr_q <= word_idx_q[ADDR_W-1:0];
                                mem_wdata_q <= {s_data, word_q};
                                word_idx_q  <= word_idx_q + 16'd1;
                                if (word_idx_q == n_q - 16'd1) begin
                                    state_q <= S_CSUM;
                                end else begin
                                    state_q <= S_DATA;
                                end
                            end
                        endcase
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_CSUM: begin
                    if (xfer_s) begin
                        if (s_data == xor_q) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end else begin
                        state_q <= S_CSUM;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_rst_n_q <= 1'b0;
                    done_q       <= 1'b0;
                    err_q        <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = ready_s;
    assign busy       = ready_s;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: table of whole frames plus hand-written
// sequences for the full-depth image and a mid-load reset.
module tb_inst_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    inst_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor: log every write and count any pair closer than 4 cycles.
    logic [7:0]  wr_addr [0:299];
    logic [31:0] wr_data [0:299];
    int wr_cnt = 0;
    int cyc = 0;
    int last_we = -100;
    int gap_bad = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_we === 1'b1) begin
            if (cyc - last_we < 4) gap_bad = gap_bad + 1;
            last_we = cyc;
            if (wr_cnt < 300) begin
                wr_addr[wr_cnt] = mem_waddr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    typedef struct {
        logic [87:0] stream;   // first byte in the most significant used position
        int          n;
        int          gap_max;
        bit          inject;
        bit          exp_done;
        bit          exp_err;
        int          exp_wr;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, input bit inject);
        int k;
        s_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start = inject && (g == 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        s_valid = 1'b1;
        s_data  = b;
        k = 0;
        while (s_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got s_ready=%b expected 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int base;
        int gap;
        v = vecs[idx];
        base = wr_cnt;
        pulse_start();
        chk($sformatf("v%0d start_ready", idx), {31'd0, s_ready}, 32'd1);
        chk($sformatf("v%0d start_flags", idx), {29'd0, core_rst_n, done, err}, 32'd0);
        for (int i = 0; i < v.n; i++) begin
            gap = (v.gap_max > 0) ? int'($urandom_range(v.gap_max, 0)) : 0;
            send(v.stream[8*(v.n-1-i) +: 8], gap, v.inject);
        end
        chk($sformatf("v%0d done", idx), {31'd0, done}, {31'd0, v.exp_done});
        chk($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d core_rst_n", idx), {31'd0, core_rst_n}, {31'd0, v.exp_done});
        chk($sformatf("v%0d ready_busy", idx), {30'd0, s_ready, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("v%0d nwrites", idx), wr_cnt - base, v.exp_wr);
        if (v.exp_wr > 0 && wr_cnt > base) begin
            chk($sformatf("v%0d w0_addr", idx), {24'd0, wr_addr[base]}, 32'd0);
            chk($sformatf("v%0d w0_data", idx), wr_data[base], v.w0);
        end
        if (v.exp_wr > 1 && wr_cnt > base + 1) begin
            chk($sformatf("v%0d w1_addr", idx), {24'd0, wr_addr[base+1]}, 32'd1);
            chk($sformatf("v%0d w1_data", idx), wr_data[base+1], v.w1);
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{88'h02_00_13_00_00_00_93_00_10_00_90, 11, 0, 1'b0, 1'b1, 1'b0, 2, 32'h0000_0013, 32'h0010_0093};
        vecs[1] = '{88'h02_00_13_00_00_00_93_00_10_00_91, 11, 0, 1'b0, 1'b0, 1'b1, 2, 32'h0000_0013, 32'h0010_0093};
        vecs[2] = '{88'h01_01,                            2,  0, 1'b0, 1'b0, 1'b1, 0, 32'h0,          32'h0};
        vecs[3] = '{88'h00_00_00,                         3,  0, 1'b0, 1'b1, 1'b0, 0, 32'h0,          32'h0};
        vecs[4] = '{88'h02_00_13_00_00_00_93_00_10_00_90, 11, 5, 1'b1, 1'b1, 1'b0, 2, 32'h0000_0013, 32'h0010_0093};
        vecs[5] = '{88'h01_00_EF_BE_AD_DE_22,             7,  0, 1'b0, 1'b1, 1'b0, 1, 32'hDEAD_BEEF,  32'h0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {23'd0, s_ready, busy, mem_we, core_rst_n, done, err, 3'd0},
            32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_ready", {31'd0, s_ready}, 32'd0);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Full-depth image: 256 words, word w = {4{w}}, checksum 00.
        base = wr_cnt;
        pulse_start();
        send(8'h00, 0, 1'b0);
        send(8'h01, 0, 1'b0);
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 4; b++) send(8'(w), 0, 1'b0);
        send(8'h00, 0, 1'b0);
        chk("full_done", {30'd0, done, core_rst_n}, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("full_nwrites", wr_cnt - base, 256);
        if (wr_cnt >= base + 256) begin
            chk("full_last_addr", {24'd0, wr_addr[base+255]}, 32'd255);
            chk("full_last_data", wr_data[base+255], 32'hFFFF_FFFF);
            chk("full_mid_data", wr_data[base+100], 32'h6464_6464);
        end

        // Reset after the 6th data byte of a 3-word frame.
        pulse_start();
        send(8'h03, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        for (int i = 1; i <= 6; i++) send(8'(8'h11 * i), 0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_flags", {25'd0, s_ready, busy, mem_we, core_rst_n, done, err, 1'b0}, 32'd0);
        chk("midrst_waddr", {24'd0, mem_waddr}, 32'd0);
        chk("midrst_wdata", mem_wdata, 32'd0);
        base = wr_cnt;
        s_valid = 1'b1;
        s_data  = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        s_valid = 1'b0;
        chk("midrst_no_writes", wr_cnt - base, 0);
        chk("midrst_idle", {30'd0, s_ready, done}, 32'd0);
        run_vec(0);

        chk("write_spacing", gap_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader that sits directly upstream of the 5-stage core's instruction memory. It receives a framed byte stream (length, instruction words, checksum) over a valid/ready interface and assembles little-endian 32-bit words. It writes those words into instruction memory through a single write port. The core is held in reset until a complete, checksum-verified image has been written.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_ready  output  1  loader can accept a byte.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_waddr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  instruction word to write.
- core_rst_n  output  1  active-low reset to the core; high only in DONE.
- busy  output  1  load in progress.
- done  output  1  last load completed with a valid checksum.
- err  output  1  last load failed.

## Operation
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count), then 4*N data bytes, then CSUM.
- Data bytes arrive least-significant first per word. Byte k of a word lands in bits [8k+7:8k].
- CSUM is the 8-bit XOR of all 4*N data bytes. Length bytes are excluded.
- A byte transfers only on a cycle where s_valid & s_ready is true.
- States and transitions:
  - IDLE -> LEN0 on start.
  - LEN0 -> LEN1 on a transfer.
  - LEN1 -> ERROR on a transfer if N > DEPTH.
  - LEN1 -> CSUM on a transfer if N == 0.
  - LEN1 -> DATA on a transfer otherwise.
  - DATA -> CSUM after the 4th byte of word N-1.
  - CSUM -> DONE on a transfer if the byte equals the running XOR.
  - CSUM -> ERROR on a transfer if it does not.
  - DONE or ERROR -> LEN0 on start.
- A new load (start in IDLE, DONE or ERROR) clears done and err and zeroes the byte counter, word index and XOR accumulator. core_rst_n drops the same cycle the state leaves DONE.
- start in LEN0, LEN1, DATA or CSUM is ignored.
- Word index counts 0..N-1. It is never wider than ADDR_W for a write, because N <= DEPTH is guaranteed.
- Words already written before an ERROR remain in memory. core_rst_n stays low after an error.
- s_ready = 1 exactly in LEN0, LEN1, DATA and CSUM. It is combinational from state.
- busy = s_ready.
- done = 1 in DONE; err = 1 in ERROR. Both are registered state decodes.

## Timing
- Reset values: state IDLE, s_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, core_rst_n 0, busy 0, done 0, err 0.
- Reset asserted at any point, including mid-DATA, returns to IDLE immediately. No further writes occur.
- start sampled at edge t gives state LEN0 and s_ready=1 from cycle t+1.
- Write latency: the 4th-byte transfer of a word at edge t makes mem_we=1 with valid mem_waddr and mem_wdata during cycle t+1, for exactly one cycle.
- Write stream throughput is at most one word per 4 cycles. Back-to-back writes are never closer than 4 cycles apart.
- The CSUM transfer at edge t gives DONE in cycle t+1. In that cycle done=1, core_rst_n=1 and s_ready=0.
- A failed checksum transfer at edge t gives err=1 in cycle t+1.
- An oversized length (second length byte transferred at edge t) gives err=1 in cycle t+1 with no mem_we ever asserted.
- Gaps in s_valid stall the FSM without losing state. Arbitrarily long stalls are allowed.

## Test plan
- Nominal load, ADDR_W=8: bytes 02 00 13 00 00 00 93 00 10 00 90 with continuous s_valid.
  - mem_we at word 0: addr 0, data 0x00000013.
  - mem_we at word 1: addr 1, data 0x00100093.
  - Then done=1, core_rst_n=1, err=0.
- Same frame with checksum byte 91: both writes occur, then err=1, done=0, core_rst_n=0.
- Oversize length: bytes 01 01 (N=257 > 256).
  - err=1 the cycle after the second byte.
  - mem_we is never asserted; s_ready=0 afterwards.
- Empty image: bytes 00 00 00 gives done=1 and core_rst_n=1 with zero mem_we pulses.
- Nominal frame with random 0-5 cycle s_valid gaps, plus start pulses injected mid-load:
  - Writes and final state are identical to the nominal case.
  - The extra start pulses have no effect.
- rst pulsed after the 6th data byte of a 3-word frame:
  - All outputs return to reset values.
  - Then start and the 2-word nominal frame give the nominal result.
